// File: rtl/fft_pkg.sv
// Shared types and defaults for the butterfly-stage scheduler.
package fft_pkg;

  localparam int DEF_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_BFLY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/bfly_phase_cnt.sv
// Frame-phase counter for bfly_sched: counts 0..2*SIZE-1 and wraps.
// Also flags zero, end of the first half, and end of the frame.
module bfly_phase_cnt
  import fft_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = $clog2(2 * SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             half_tc_o,
  output logic             full_tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o     = cnt_q;
  assign zero_o    = (cnt_q == '0);
  assign half_tc_o = (cnt_q == CNT_W'(SIZE - 1));
  assign full_tc_o = (cnt_q == CNT_W'(2 * SIZE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = full_tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bfly_sched.sv
// Radix-2 SDF butterfly-stage scheduler: fill / butterfly / flush sequencing.
// Optional output frame_cnt is enabled by defining BFLY_SCHED_STATS_EN.
module bfly_sched
  import fft_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = $clog2(2 * SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic                    flush,
  output logic                    shift_en,
  output logic                    bfly_en,
  output logic                    out_sel,
  output logic                    dout_valid,
  output logic [$clog2(SIZE)-1:0] tw_idx,
  output logic                    frame_start,
  output logic                    busy,
  output logic                    err_drop
`ifdef BFLY_SCHED_STATS_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int TW_W = $clog2(SIZE);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             cnt_inc, cnt_clr;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_zero, cnt_half, cnt_full;

  logic             shift_en_q, shift_en_d;
  logic             bfly_en_q, bfly_en_d;
  logic             out_sel_q, out_sel_d;
  logic             dout_valid_q, dout_valid_d;
  logic [TW_W-1:0]  tw_idx_q, tw_idx_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q;
  logic             err_drop_q, err_drop_d;

  bfly_phase_cnt #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (cnt_inc),
    .clr_i     (cnt_clr),
    .cnt_o     (cnt_q),
    .zero_o    (cnt_zero),
    .half_tc_o (cnt_half),
    .full_tc_o (cnt_full)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b0;
    shift_en_d    = 1'b0;
    bfly_en_d     = 1'b0;
    out_sel_d     = 1'b0;
    dout_valid_d  = 1'b0;
    tw_idx_d      = '0;
    frame_start_d = 1'b0;
    err_drop_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          state_d       = ST_FILL;
          cnt_inc       = 1'b1;
          shift_en_d    = 1'b1;
          out_sel_d     = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (din_valid) begin
          shift_en_d    = 1'b1;
          out_sel_d     = 1'b1;
          dout_valid_d  = pending_q;
          frame_start_d = cnt_zero;
          cnt_inc       = 1'b1;
          if (cnt_half) begin
            state_d   = ST_BFLY;
            pending_d = 1'b0;
          end
        end else if (flush && cnt_zero && pending_q) begin
          // Only a frame boundary with differences still buffered can drain.
          state_d = ST_FLUSH;
          cnt_clr = 1'b1;
        end
      end
      ST_BFLY: begin
        if (din_valid) begin
          shift_en_d   = 1'b1;
          bfly_en_d    = 1'b1;
          dout_valid_d = 1'b1;
          tw_idx_d     = TW_W'(cnt_q - CNT_W'(SIZE));
          cnt_inc      = 1'b1;
          if (cnt_full) begin
            state_d   = ST_FILL;
            pending_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        shift_en_d   = 1'b1;
        out_sel_d    = 1'b1;
        dout_valid_d = 1'b1;
        err_drop_d   = din_valid;
        cnt_inc      = 1'b1;
        if (cnt_half) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= 1'b0;
      shift_en_q    <= 1'b0;
      bfly_en_q     <= 1'b0;
      out_sel_q     <= 1'b0;
      dout_valid_q  <= 1'b0;
      tw_idx_q      <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      shift_en_q    <= shift_en_d;
      bfly_en_q     <= bfly_en_d;
      out_sel_q     <= out_sel_d;
      dout_valid_q  <= dout_valid_d;
      tw_idx_q      <= tw_idx_d;
      frame_start_q <= frame_start_d;
      busy_q        <= (state_d != ST_IDLE);
      err_drop_q    <= err_drop_d;
    end
  end

`ifdef BFLY_SCHED_STATS_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (state_q == ST_BFLY && state_d == ST_FILL) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign shift_en    = shift_en_q;
  assign bfly_en     = bfly_en_q;
  assign out_sel     = out_sel_q;
  assign dout_valid  = dout_valid_q;
  assign tw_idx      = tw_idx_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_bfly_sched.sv
// Self-checking bench for bfly_sched (SIZE = 16) with a stream-level reference model.
module tb_bfly_sched;

  localparam int SIZE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       flush;
  logic       shift_en, bfly_en, out_sel, dout_valid;
  logic [3:0] tw_idx;
  logic       frame_start, busy, err_drop;
`ifdef BFLY_SCHED_STATS_EN
  logic [15:0] frame_cnt;
`endif

  bfly_sched #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .flush       (flush),
    .shift_en    (shift_en),
    .bfly_en     (bfly_en),
    .out_sel     (out_sel),
    .dout_valid  (dout_valid),
    .tw_idx      (tw_idx),
    .frame_start (frame_start),
    .busy        (busy),
    .err_drop    (err_drop)
`ifdef BFLY_SCHED_STATS_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [10:0] obs_vec = {shift_en, bfly_en, out_sel, dout_valid, tw_idx,
                         frame_start, busy, err_drop};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a stream is just a count of accepted blocks; the frame
  // position is that count modulo 2*SIZE, and a flush is a countdown.
  int          stream_blocks = 0;
  bit          active        = 0;
  bit          flushing      = 0;
  int          flush_left    = 0;
  logic [10:0] exp_vec       = '0;

  task automatic model_clear();
    stream_blocks = 0;
    active        = 0;
    flushing      = 0;
    flush_left    = 0;
    exp_vec       = '0;
  endtask

  // Drive one cycle of inputs, predict the registered outputs, advance a clock.
  task automatic step(input bit din, input bit fl);
    logic s, b, o, dv, fs, ed;
    logic [3:0] tw;
    int pos;
    din_valid = din;
    flush     = fl;
    s = 0; b = 0; o = 0; dv = 0; fs = 0; ed = 0; tw = '0;
    pos = stream_blocks % (2 * SIZE);
    if (flushing) begin
      s = 1; o = 1; dv = 1; ed = din;
      flush_left--;
      if (flush_left == 0) begin
        flushing = 0;
        active = 0;
        stream_blocks = 0;
      end
    end else if (!active) begin
      if (din) begin
        s = 1; o = 1; fs = 1;
        active = 1;
        stream_blocks = 1;
      end
    end else if (din) begin
      s  = 1;
      fs = (pos == 0);
      if (pos < SIZE) begin
        o  = 1;
        dv = (stream_blocks >= 2 * SIZE);
      end else begin
        b  = 1;
        dv = 1;
        tw = 4'(pos - SIZE);
      end
      stream_blocks++;
    end else if (fl && pos == 0) begin
      flushing = 1;
      flush_left = SIZE;
    end
    exp_vec = {s, b, o, dv, tw, fs, (active || flushing), ed};
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    flush = 1'b0;
    #12;
    n_total++;
    if (obs_vec !== 11'b0) $display("FAIL reset_outputs: got %b want %b", obs_vec, 11'b0);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    step(1'b0, 1'b0);
    n_total++;
    if (obs_vec !== 11'b0) $display("FAIL idle_after_reset: got %b want %b", obs_vec, 11'b0);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_fill_bfly();
    apply_reset();
    for (int i = 1; i <= 2 * SIZE; i++) begin
      step(1'b1, 1'b0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL fill_bfly_vec blk %0d: got %b want %b", i, obs_vec, exp_vec);
      else n_pass++;
      n_total++;
      if (i <= SIZE) begin
        if ({shift_en, bfly_en, dout_valid} !== 3'b100)
          $display("FAIL fill_strobes blk %0d: got %b want 100", i, {shift_en, bfly_en, dout_valid});
        else n_pass++;
      end else begin
        if ({bfly_en, dout_valid, tw_idx} !== {2'b11, 4'(i - SIZE - 1)})
          $display("FAIL bfly_tw blk %0d: got %b want %b", i, {bfly_en, dout_valid, tw_idx},
                   {2'b11, 4'(i - SIZE - 1)});
        else n_pass++;
      end
    end
    $display("test_fill_bfly done");
  endtask

  task automatic test_back_to_back();
    int fs_blocks[$];
    apply_reset();
    for (int i = 1; i <= 4 * SIZE; i++) begin
      step(1'b1, 1'b0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_vec blk %0d: got %b want %b", i, obs_vec, exp_vec);
      else n_pass++;
      if (frame_start === 1'b1) fs_blocks.push_back(i);
      if (i > 2 * SIZE && i <= 3 * SIZE) begin
        n_total++;
        if ({out_sel, dout_valid} !== 2'b11)
          $display("FAIL diff_out blk %0d: got %b want 11", i, {out_sel, dout_valid});
        else n_pass++;
      end
    end
    n_total++;
    if (fs_blocks.size() != 2 || fs_blocks[0] != 1 || fs_blocks[1] != 2 * SIZE + 1)
      $display("FAIL frame_start_pulses: got %0d pulses want 2 at blocks 1 and %0d",
               fs_blocks.size(), 2 * SIZE + 1);
    else n_pass++;
    $display("test_back_to_back done");
  endtask

  // Runs a flush already accepted; optionally injects din_valid at one step.
  task automatic run_flush(input string tag, input int inject_at);
    int n_dv, n_err;
    bit done;
    n_dv = 0; n_err = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(c == inject_at, 1'b0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL %s_vec cyc %0d: got %b want %b", tag, c, obs_vec, exp_vec);
      else n_pass++;
      if (dout_valid === 1'b1 && out_sel === 1'b1) n_dv++;
      if (err_drop === 1'b1) n_err++;
      if (busy === 1'b0) done = 1;
    end
    n_total++;
    if (n_dv != SIZE || busy !== 1'b0)
      $display("FAIL %s_len: got %0d steps busy=%b want %0d steps busy=0", tag, n_dv, busy, SIZE);
    else n_pass++;
    n_total++;
    if (n_err != ((inject_at >= 0) ? 1 : 0))
      $display("FAIL %s_err_drop: got %0d pulses want %0d", tag, n_err, (inject_at >= 0) ? 1 : 0);
    else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (obs_vec !== 11'b0) $display("FAIL %s_after: got %b want %b", tag, obs_vec, 11'b0);
    else n_pass++;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 2 * SIZE; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_total++;
    if (obs_vec !== exp_vec || busy !== 1'b1)
      $display("FAIL flush_accept: got %b want %b", obs_vec, exp_vec);
    else n_pass++;
    run_flush("flush", -1);
    $display("test_flush done");
  endtask

  task automatic test_flush_ignore_drop();
    apply_reset();
    for (int i = 0; i < 2 * SIZE + 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_total++;
    if (obs_vec !== exp_vec || obs_vec !== 11'b00000000010)
      $display("FAIL flush_ignored: got %b want %b", obs_vec, 11'b00000000010);
    else n_pass++;
    for (int i = 0; i < 2 * SIZE - 5; i++) begin
      step(1'b1, 1'b0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL post_ignore_vec blk %0d: got %b want %b", i, obs_vec, exp_vec);
      else n_pass++;
    end
    step(1'b0, 1'b1);
    run_flush("flush_drop", 3);
    $display("test_flush_ignore_drop done");
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int i = 1; i <= 2 * SIZE; i++) begin
      step(1'b1, 1'b0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL gap_blk_vec blk %0d: got %b want %b", i, obs_vec, exp_vec);
      else n_pass++;
      n_total++;
      if (i > SIZE && tw_idx !== 4'(i - SIZE - 1))
        $display("FAIL gap_tw blk %0d: got %0d want %0d", i, tw_idx, i - SIZE - 1);
      else if (i <= SIZE && {shift_en, bfly_en, dout_valid} !== 3'b100)
        $display("FAIL gap_fill blk %0d: got %b want 100", i, {shift_en, bfly_en, dout_valid});
      else n_pass++;
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0);
        n_total++;
        if (obs_vec !== exp_vec || {shift_en, bfly_en, dout_valid, frame_start} !== 4'b0)
          $display("FAIL gap_idle blk %0d gap %0d: got %b want %b", i, g, obs_vec, exp_vec);
        else n_pass++;
      end
    end
    $display("test_gaps done");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
    din_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (obs_vec !== 11'b0) $display("FAIL async_reset: got %b want %b", obs_vec, 11'b0);
    else n_pass++;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    step(1'b1, 1'b0);
    n_total++;
    if (obs_vec !== exp_vec || {frame_start, shift_en, out_sel, dout_valid} !== 4'b1110)
      $display("FAIL restart_frame: got %b want %b", obs_vec, exp_vec);
    else n_pass++;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      n_total++;
      if (obs_vec !== exp_vec) $display("FAIL random_vec cyc %0d: got %b want %b", c, obs_vec, exp_vec);
      else n_pass++;
    end
    $display("test_random done");
  endtask

  initial begin
    din_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    test_reset();
    test_fill_bfly();
    test_back_to_back();
    test_flush();
    test_flush_ignore_drop();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bfly_sched.md
BFLY_SCHED -- requirements
Module: bfly_sched

Interface
REQ-001 Parameter SIZE, default 16, meaning delay-buffer depth in input blocks; a power of two, at least 2.
REQ-002 Parameter CNT_W, default $clog2(2*SIZE), meaning frame-phase counter width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din_valid  input  1  one parallel input block is present this cycle.
REQ-006 flush  input  1  request to drain buffered difference outputs after the input stream ends.
REQ-007 shift_en  output  1  advance the delay buffer by one block.
REQ-008 bfly_en  output  1  butterfly computes on the buffer head and the incoming block.
REQ-009 out_sel  output  1  output mux select: 0 = butterfly sum path, 1 = delay-buffer head.
REQ-010 dout_valid  output  1  stage output block is valid.
REQ-011 tw_idx  output  $clog2(SIZE)  twiddle ROM index for the current butterfly.
REQ-012 frame_start  output  1  first block of a frame accepted.
REQ-013 busy  output  1  state is not IDLE.
REQ-014 err_drop  output  1  din_valid arrived during FLUSH and was discarded.

Function
REQ-015 The block SHALL be a four-state FSM (IDLE, FILL, BFLY, FLUSH) with a phase counter cnt (CNT_W bits) and a pending flag.
- pending = 1 means differences from the last butterfly phase are still held in the buffer.
REQ-016 All outputs SHALL be registered, asserted in the cycle after the triggering din_valid or FLUSH tick (latency 1).
REQ-017 IDLE: din_valid -> FILL, cnt <= 1; shift_en = 1, out_sel = 1, frame_start = 1 and dout_valid = 0 in the next cycle.
REQ-018 FILL with din_valid: shift_en = 1, out_sel = 1, dout_valid = pending, cnt increments; frame_start = 1 when cnt was 0.
- cnt = SIZE-1 -> BFLY, and pending clears.
REQ-019 BFLY with din_valid: shift_en = 1, bfly_en = 1, out_sel = 0, dout_valid = 1, tw_idx = cnt - SIZE, cnt increments.
- cnt = 2*SIZE-1 -> cnt wraps to 0, state -> FILL, pending <= 1.
REQ-020 In FILL and BFLY, cycles without din_valid SHALL hold cnt and state and drive all strobes 0; gaps of any length are legal.
REQ-021 flush SHALL be accepted only when all hold: state FILL, cnt = 0, pending = 1, din_valid = 0.
- On acceptance: state -> FLUSH with cnt <= 0.
- In every other condition flush is ignored, with no side effects.
REQ-022 FLUSH SHALL issue one internal step per cycle for SIZE cycles: shift_en = 1, out_sel = 1, dout_valid = 1.
- After the SIZE-th step: state -> IDLE, pending <= 0.
REQ-023 din_valid during FLUSH SHALL be discarded; err_drop pulses for one cycle per discarded block; the FLUSH count is unaffected.
REQ-024 tw_idx SHALL read 0 whenever bfly_en = 0.
REQ-025 cnt SHALL wrap only at 2*SIZE-1 and never exceed it.

Reset
REQ-026 rst SHALL force state IDLE, cnt = 0 and pending = 0, and drive every output to 0, independent of clk.
REQ-027 rst asserted mid-frame or mid-FLUSH SHALL discard all progress; the first din_valid after release starts a new frame.

Configuration
REQ-028 With macro BFLY_SCHED_STATS_EN defined, the block SHALL add output frame_cnt [15:0]:
- increments (wrapping) at each BFLY -> FILL transition;
- resets to 0.
REQ-029 Without BFLY_SCHED_STATS_EN, frame_cnt and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package fft_pkg SHALL hold the state enum type and the default SIZE constant.
REQ-031 The phase counter with wrap and terminal-count flags SHALL be sub-module bfly_phase_cnt; the FSM and output registers stay in bfly_sched.

Verification (SIZE = 16)
REQ-032 Reset, then 32 back-to-back din_valid:
- cycles 1..16 show shift_en = 1, bfly_en = 0, dout_valid = 0;
- cycles 17..32 show bfly_en = 1, dout_valid = 1, tw_idx = 0..15.
REQ-033 64 back-to-back din_valid:
- blocks 33..48 show out_sel = 1, dout_valid = 1;
- frame_start pulses at blocks 1 and 33.
REQ-034 32 din_valid, then flush -> exactly 16 cycles of dout_valid = 1, out_sel = 1, then busy = 0.
REQ-035 flush at cnt = 5 in FILL is ignored; din_valid during FLUSH gives err_drop = 1 for 1 cycle and the 16-step flush still completes.
REQ-036 din_valid alternating with 3-cycle gaps -> the same strobe sequence as REQ-032 with the gaps inserted, and cnt held during each gap.
REQ-037 rst asserted at BFLY block 20 -> all outputs 0 immediately; the next din_valid produces frame_start = 1 and a fresh FILL.
